// File: rtl/round_decrypt_pkg.sv
// ----------------------------------------------------------------------------
// round_decrypt_pkg
// Shared definitions for the inverse SPECK round.
//   - Default word width and rotate amounts used as parameter defaults.
//   - Decrypt state codes, which sit next to the encrypt codes in the
//     round-function definitions. Codes above MAX_STATE_DECRYPT are unused.
// No ports (package).
// ----------------------------------------------------------------------------
package round_decrypt_pkg;

  localparam int BLOCK_SIZE     = 32;
  localparam int SHIFT_WIDTH_P0 = 8;
  localparam int SHIFT_WIDTH_P1 = 3;

  localparam int STATE_W = 4;

  // The 4-bit encoding leaves codes 7..15 unused; the FSM sends them to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE_DECRYPT      = 4'd0,
    LOAD_DECRYPT      = 4'd1,
    XOR_WORDS_DECRYPT = 4'd2,
    ROT_KEY_DECRYPT   = 4'd3,
    SUB_DECRYPT       = 4'd4,
    ROL_X0_DECRYPT    = 4'd5,
    RESULT_DECRYPT    = 4'd6
  } dec_state_e;

  localparam logic [STATE_W-1:0] MAX_STATE_DECRYPT = 4'd6;

endpackage

// File: rtl/round_decrypt.sv
// ----------------------------------------------------------------------------
// round_decrypt
// Inverse SPECK round: undoes one encryption round of a 2-word block using
// one round subkey, as a multi-cycle state machine.
//
// Parameters:
//   WORD_W  word width (block is 2*WORD_W bits)
//   ALPHA   rotate amount on the low word  (must be < WORD_W)
//   BETA    rotate amount on the high word (must be < WORD_W)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   subkey          round key, held stable from start acceptance to finished
//   ciphertext      {c1 (high), c0 (low)}
//   plaintext       {x1 (high), x0 (low)}, valid while finished is high
//   signal_start    level request, accepted in IDLE only when armed
//   finished        high when plaintext is valid
//   state_response  current state code (debug only)
//
// Configuration macro:
//   SPECK_DEC_MERGED_EN  when defined, LOAD computes the whole inverse round
//                        in one step and jumps straight to RESULT (latency 2).
//                        When undefined, the 7-state sequence is used.
// ----------------------------------------------------------------------------
module round_decrypt
  import round_decrypt_pkg::*;
#(
  parameter int WORD_W = BLOCK_SIZE,
  parameter int ALPHA  = SHIFT_WIDTH_P0,
  parameter int BETA   = SHIFT_WIDTH_P1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     subkey,
  input  logic [2*WORD_W-1:0]   ciphertext,
  output logic [2*WORD_W-1:0]   plaintext,
  input  logic                  signal_start,
  output logic                  finished,
  output logic [STATE_W-1:0]    state_response
);

  dec_state_e        state;
  logic [WORD_W-1:0] x0;
  logic [WORD_W-1:0] x1;
  logic              armed;

  // True rotates; a rotate by 0 degenerates to v | 0 because a shift by the
  // full width yields zero.
  function automatic logic [WORD_W-1:0] ror_beta(input logic [WORD_W-1:0] v);
    return (v >> BETA) | (v << (WORD_W - BETA));
  endfunction

  function automatic logic [WORD_W-1:0] rol_alpha(input logic [WORD_W-1:0] v);
    return (v << ALPHA) | (v >> (WORD_W - ALPHA));
  endfunction

`ifdef SPECK_DEC_MERGED_EN
  // Whole inverse round in one combinational step, same operation order as
  // the multi-cycle path so results are bit-identical.
  logic [WORD_W-1:0] merged_x1;
  logic [WORD_W-1:0] merged_x0;

  always_comb begin
    merged_x1 = ror_beta(ciphertext[2*WORD_W-1:WORD_W] ^ ciphertext[WORD_W-1:0]);
    merged_x0 = rol_alpha((ciphertext[WORD_W-1:0] ^ subkey) - merged_x1);
  end
`endif

  assign state_response = state;

  // Single FSM block: state, datapath words, handshake and registered outputs.
  // armed re-arms whenever start is seen low, so a start held high through
  // RESULT cannot retrigger the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE_DECRYPT;
      x0        <= '0;
      x1        <= '0;
      armed     <= 1'b1;
      finished  <= 1'b0;
      plaintext <= '0;
    end else begin
      if (!signal_start) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE_DECRYPT: begin
          if (signal_start && armed) begin
            finished <= 1'b0;
            armed    <= 1'b0;
            state    <= LOAD_DECRYPT;
          end
        end
        LOAD_DECRYPT: begin
`ifdef SPECK_DEC_MERGED_EN
          x0    <= merged_x0;
          x1    <= merged_x1;
          state <= RESULT_DECRYPT;
`else
          x0    <= ciphertext[WORD_W-1:0];
          x1    <= ciphertext[2*WORD_W-1:WORD_W];
          state <= XOR_WORDS_DECRYPT;
`endif
        end
        XOR_WORDS_DECRYPT: begin
          x1    <= x1 ^ x0;
          state <= ROT_KEY_DECRYPT;
        end
        ROT_KEY_DECRYPT: begin
          x1    <= ror_beta(x1);
          x0    <= x0 ^ subkey;
          state <= SUB_DECRYPT;
        end
        SUB_DECRYPT: begin
          // Modular subtract; the borrow out is intentionally dropped.
          x0    <= x0 - x1;
          state <= ROL_X0_DECRYPT;
        end
        ROL_X0_DECRYPT: begin
          x0    <= rol_alpha(x0);
          state <= RESULT_DECRYPT;
        end
        RESULT_DECRYPT: begin
          plaintext <= {x1, x0};
          finished  <= 1'b1;
          state     <= IDLE_DECRYPT;
        end
        default: begin
          state <= IDLE_DECRYPT;
        end
      endcase
    end
  end

endmodule
